multu_hilo_unit: RTL

Multi-cycle unsigned multiplier with architectural Hi/Lo registers. It sits in the EX stage beside the ALU and consumes the MULTU / MFHI / MFLO strobes produced by ALU control. It computes a 2×WIDTH-bit unsigned product by iterative shift-add, holds it in Hi/Lo, and serves Hi/Lo reads to the EX result mux. It requests a pipeline stall while a multiply is in flight.

---
 rtl/multu_pkg.sv | 18 +
 rtl/multu_shift_add_core.sv | 36 +++
 rtl/multu_hilo_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/multu_pkg.sv
// Shared types and sizing for the MULTU/MFHI/MFLO multiplier unit.
package multu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    // Iteration counter width for a given operand width (never zero bits).
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/multu_shift_add_core.sv
// Shift-add product register: one unsigned iteration per enabled cycle.
module multu_shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     sum;

    // product is the register value after this cycle's iteration, so the
    // owner can capture the final result on the same edge as the last step.
    always_comb begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            sum = sum + {1'b0, a_q};
        end
        product = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a;
            acc <= {{WIDTH{1'b0}}, b};
        end else if (step) begin
            acc <= product;
        end
    end

endmodule

// File: rtl/multu_hilo_unit.sv
// Multi-cycle unsigned multiplier with architectural Hi/Lo and a stall request
// for the EX stage.
module multu_hilo_unit
    import multu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [2*WIDTH-1:0] product;
    logic               accept;
    logic               step;

    assign accept = start && (state != RUN) && !rst;
    assign step   = (state == RUN);

    multu_shift_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .load   (accept),
        .step   (step),
        .a      (op_a),
        .b      (op_b),
        .product(product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (count == LAST) begin
                        hi    <= product[2*WIDTH-1:WIDTH];
                        lo    <= product[WIDTH-1:0];
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Hi wins when both strobes are raised.
    always_comb begin
        rdata = '0;
        if (rd_hi) begin
            rdata = hi;
        end else if (rd_lo) begin
            rdata = lo;
        end
    end

    assign stall = busy & (start | rd_hi | rd_lo);

endmodule
